ps2_voice_alloc: RTL
====================

PS2_VOICE_ALLOC -- requirements
Module: ps2_voice_alloc

Interface
REQ-001 Parameter TIMEOUT_CYC, 50000, max CLOCK_50 cycles between PS2_CLK falling edges inside a frame before abort.
REQ-002 Parameter SYNC_STAGES, 2, synchronizer depth on PS2_CLK and PS2_DAT (min 2).
REQ-003 CLOCK_50  in  1  sole system clock, all logic rising-edge.
REQ-004 RESET_N  in  1  reset; asynchronous assert, active-low.
REQ-005 PS2_CLK  in  1  raw keyboard clock, asynchronous.
REQ-006 PS2_DAT  in  1  raw keyboard data, asynchronous.
REQ-007 scan_code1..scan_code4  out  8 each  per-voice held make code; 8'hF0 = voice silent.
REQ-008 voice_busy  out  4  bit k-1 high when scan_codek != 8'hF0.
REQ-009 frame_err  out  1  one-cycle pulse on a discarded frame.
REQ-010 steal  out  1  one-cycle pulse when an occupied voice is reassigned.

Function
REQ-011 PS2_CLK and PS2_DAT SHALL pass through SYNC_STAGES flops; a frame bit is sampled on the cycle a synchronized PS2_CLK falling edge is detected.
REQ-012 Receiver FSM SHALL be IDLE -> DATA (8 bits, LSB first) -> PARITY -> STOP -> IDLE; IDLE leaves only on a sampled start bit of 0.
REQ-013 Byte SHALL be accepted only if odd parity over data+parity holds and stop bit is 1; otherwise discard and pulse frame_err.
REQ-014 In any state other than IDLE, TIMEOUT_CYC cycles without a falling edge SHALL return FSM to IDLE and pulse frame_err; an edge on the expiry cycle wins over the timeout.
REQ-015 Accepted byte 8'hE0 SHALL set ext flag; 8'hF0 SHALL set brk flag; neither alters voices.
REQ-016 Next accepted byte with ext set SHALL be discarded and both flags cleared (extended keys unused).
REQ-017 Bytes 8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF SHALL be ignored and clear both flags.
REQ-018 Make code already held by any voice SHALL be ignored (typematic repeat).
REQ-019 New make code SHALL go to lowest-index free voice; if none free, to occupied voice with highest age, ties to lowest index, with steal pulsed.
REQ-020 Age: 2-bit per voice; on assignment target age=0 and every other occupied voice age increments, saturating at 3.
REQ-021 Break (brk set + code) SHALL write 8'hF0 to every voice holding that code and clear brk; no match -> no change.
REQ-022 scan_code*/voice_busy SHALL update on the cycle after the stop bit is sampled (latency 1 cycle from stop edge); steal pulses on that same cycle.
REQ-023 Only one byte is processed per frame; at most one voice changes per accepted byte.

Reset
REQ-024 RESET_N low SHALL immediately force scan_code1..4=8'hF0, voice_busy=0, frame_err=0, steal=0, ages=0, flags clear, FSM IDLE, timeout counter 0, synchronizers to 1.
REQ-025 Reset asserted mid-frame SHALL abandon the frame with no voice change and no frame_err.

Structure
REQ-026 Shared package ps2_pkg SHALL hold SC_BREAK=8'hF0, SC_EXT=8'hE0, ignored-code constants, and receiver state enum.
REQ-027 Frame receiver (REQ-011..014) SHALL be sub-module ps2_rx emitting byte plus one-cycle valid; allocation logic stays in ps2_voice_alloc.

Verification
REQ-028 Reset released, no traffic -> all scan_code=8'hF0, voice_busy=4'b0000, no pulses.
REQ-029 Valid frame 8'h1C -> scan_code1=8'h1C one cycle after stop edge, voice_busy=4'b0001; repeat 8'h1C -> unchanged.
REQ-030 Frames 1C,1B,23,2B then 34 -> scan_code1=34, others 1B,23,2B, steal one pulse; then F0,1B -> scan_code2=F0, voice_busy=4'b1101.
REQ-031 Frame 8'h1C with wrong parity -> frame_err one cycle, outputs unchanged.
REQ-032 Start+4 data bits then PS2_CLK held high -> frame_err exactly TIMEOUT_CYC cycles after last edge; following valid frame 8'h23 decodes correctly.
REQ-033 Frames E0,1C -> no voice change; RESET_N pulsed while voices held -> all scan_code=8'hF0 asynchronously.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 constants: special scan codes, ignored controller responses,
// voice count and the receiver state encoding.
package ps2_pkg;

  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_NULL   = 8'h00;
  localparam logic [7:0] SC_BAT_OK = 8'hAA;
  localparam logic [7:0] SC_ECHO   = 8'hEE;
  localparam logic [7:0] SC_ACK    = 8'hFA;
  localparam logic [7:0] SC_RESEND = 8'hFE;
  localparam logic [7:0] SC_ERR    = 8'hFF;

  localparam int NUM_VOICES = 4;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  // Keyboard housekeeping bytes that never represent a key.
  function automatic logic is_ignored(input logic [7:0] code);
    return code inside {SC_NULL, SC_BAT_OK, SC_ECHO, SC_ACK, SC_RESEND, SC_ERR};
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: synchronizes the raw lines, samples on PS2 clock falls,
// checks odd parity and stop bit, and aborts stalled frames after a timeout.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYC = 50000,
  parameter int SYNC_STAGES = 2    // must be at least 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
  logic                   clk_prev;
  logic                   clk_s, dat_s, fall, expire;

  rx_state_e     state, state_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    shreg, shreg_n;
  logic          par, par_n;
  logic [CW-1:0] tcnt, tcnt_n;

  // Idle PS/2 lines are high, so the synchronizers reset to 1 to avoid a
  // phantom falling edge right after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync <= '1;
      dat_sync <= '1;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_dat};
      clk_prev <= clk_s;
    end
  end

  assign clk_s  = clk_sync[SYNC_STAGES-1];
  assign dat_s  = dat_sync[SYNC_STAGES-1];
  assign fall   = clk_prev & ~clk_s;
  // An edge arriving on the expiry cycle is served instead of aborting.
  assign expire = (state != RX_IDLE) && !fall && (tcnt == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RX_IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      par     <= 1'b0;
      tcnt    <= '0;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      shreg   <= shreg_n;
      par     <= par_n;
      tcnt    <= tcnt_n;
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave one unassigned and infer a latch.
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    shreg_n    = shreg;
    par_n      = par;
    byte_valid = 1'b0;
    frame_err  = 1'b0;

    unique case (state)
      RX_IDLE: begin
        if (fall && !dat_s) begin
          state_n   = RX_DATA;
          bit_cnt_n = '0;
        end
      end
      RX_DATA: begin
        if (fall) begin
          shreg_n   = {dat_s, shreg[7:1]};
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_n = RX_PARITY;
        end
      end
      RX_PARITY: begin
        if (fall) begin
          par_n   = dat_s;
          state_n = RX_STOP;
        end
      end
      RX_STOP: begin
        if (fall) begin
          state_n = RX_IDLE;
          if ((^{shreg, par}) && dat_s) byte_valid = 1'b1;
          else                          frame_err  = 1'b1;
        end
      end
      default: state_n = RX_IDLE;
    endcase

    if (expire) begin
      state_n   = RX_IDLE;
      frame_err = 1'b1;
    end

    if (fall || expire || state == RX_IDLE) tcnt_n = '0;
    else                                    tcnt_n = tcnt + CW'(1);
  end

  assign rx_byte = shreg;

endmodule

// File: rtl/ps2_voice_alloc.sv
// Four-voice key allocator: tracks held make codes from a PS/2 keyboard,
// releases them on break codes and steals the oldest voice when all are busy.
module ps2_voice_alloc
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYC = 50000,
  parameter int SYNC_STAGES = 2
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic [7:0] scan_code1,
  output logic [7:0] scan_code2,
  output logic [7:0] scan_code3,
  output logic [7:0] scan_code4,
  output logic [3:0] voice_busy,
  output logic       frame_err,
  output logic       steal
);

  logic [7:0] rx_byte;
  logic       byte_valid, rx_err;

  ps2_rx #(
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_rx (
    .clk       (CLOCK_50),
    .rst_n     (RESET_N),
    .ps2_clk   (PS2_CLK),
    .ps2_dat   (PS2_DAT),
    .rx_byte   (rx_byte),
    .byte_valid(byte_valid),
    .frame_err (rx_err)
  );

  logic [NUM_VOICES-1:0][7:0] voice, voice_n;
  logic [NUM_VOICES-1:0][1:0] age, age_n;
  logic                       ext, ext_n, brk, brk_n, steal_n;
  logic [NUM_VOICES-1:0]      busy, hit;
  logic                       any_free;
  logic [1:0]                 free_idx, old_idx, target;
  logic [1:0]                 old_age;

  always_comb begin
    any_free = 1'b0;
    free_idx = '0;
    old_idx  = '0;
    old_age  = age[0];
    for (int k = 0; k < NUM_VOICES; k++) begin
      busy[k] = (voice[k] != SC_BREAK);
      hit[k]  = (voice[k] == rx_byte);
    end
    // Descending scan so the lowest free index is the last one written.
    for (int k = NUM_VOICES - 1; k >= 0; k--) begin
      if (!busy[k]) begin
        any_free = 1'b1;
        free_idx = 2'(k);
      end
    end
    // Strict compare keeps the lowest index on equal ages.
    for (int k = 1; k < NUM_VOICES; k++) begin
      if (age[k] > old_age) begin
        old_age = age[k];
        old_idx = 2'(k);
      end
    end
    target = any_free ? free_idx : old_idx;
  end

  always_comb begin
    voice_n = voice;
    age_n   = age;
    ext_n   = ext;
    brk_n   = brk;
    steal_n = 1'b0;

    if (byte_valid) begin
      if (ext) begin
        ext_n = 1'b0;
        brk_n = 1'b0;
      end else if (rx_byte == SC_EXT) begin
        ext_n = 1'b1;
      end else if (rx_byte == SC_BREAK) begin
        brk_n = 1'b1;
      end else if (is_ignored(rx_byte)) begin
        brk_n = 1'b0;
      end else if (brk) begin
        brk_n = 1'b0;
        for (int k = 0; k < NUM_VOICES; k++)
          if (hit[k]) voice_n[k] = SC_BREAK;
      end else if (!(|hit)) begin
        voice_n[target] = rx_byte;
        steal_n         = !any_free;
        for (int k = 0; k < NUM_VOICES; k++) begin
          if (2'(k) == target)              age_n[k] = 2'd0;
          else if (busy[k] && age[k] != 2'd3) age_n[k] = age[k] + 2'd1;
        end
      end
    end
  end

  // NOTE: the voice table is only four registers and must read as silent the
  // instant reset asserts, so it is a reset flop array rather than a RAM.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      voice     <= {NUM_VOICES{SC_BREAK}};
      age       <= '0;
      ext       <= 1'b0;
      brk       <= 1'b0;
      frame_err <= 1'b0;
      steal     <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      voice     <= voice_n;
      age       <= age_n;
      ext       <= ext_n;
      brk       <= brk_n;
      frame_err <= rx_err;
      steal     <= steal_n;
    end
  end

  assign scan_code1 = voice[0];
  assign scan_code2 = voice[1];
  assign scan_code3 = voice[2];
  assign scan_code4 = voice[3];
  assign voice_busy = busy;

endmodule
